// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch stage and its next-PC mux:
//   FSM state encodings, the nop encoding used for squashed slots, the PC
//   increment, and small helpers for jump-target formation and saturating
//   performance counters.
package fetch_pkg;

  // What the most recent clock edge did to the IF/ID register.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,  // normal fetch
    ST_HOLD   = 2'd1,  // previous edge was a stall
    ST_SQUASH = 2'd2   // previous edge inserted a bubble
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  // MIPS j/jal target: upper nibble of the delay-slot PC, 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

  // Performance counters stick at all-ones rather than wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// next_pc_sel
//   Combinational next-PC priority mux. Also used standalone by the hazard
//   unit's verification model, so it carries no state.
//   Priority: reset, jr, j/jal, taken branch, stall (hold), sequential.
// Ports
//   rst_i            reset asserted: select RESET_PC
//   pc_i             current PC
//   stall_i          hold the PC
//   branch_taken_i   taken branch, target in branch_target_i
//   jump_i           j/jal, word index in jump_index_i
//   jump_reg_i       jr, target in jump_reg_target_i
//   address_o        next PC, bits [1:0] forced to zero
//   pc_plus4_o       pc_i + 4, modulo 2^32
//   target_misaligned_o  the selected redirect target had nonzero bits [1:0]
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              rst_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [DATA_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jump_reg_i,
  input  logic [DATA_W-1:0] jump_reg_target_i,
  output logic [DATA_W-1:0] address_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic              target_misaligned_o
);

  logic [DATA_W-1:0] raw_addr;
  logic              redirect;

  assign pc_plus4_o = pc_i + PC_INCR;
  assign redirect   = jump_reg_i | jump_i | branch_taken_i;

  always_comb begin
    raw_addr = pc_plus4_o;
    if (rst_i)               raw_addr = RESET_PC;
    else if (jump_reg_i)     raw_addr = jump_reg_target_i;
    else if (jump_i)         raw_addr = jump_target(pc_plus4_o, jump_index_i);
    else if (branch_taken_i) raw_addr = branch_target_i;
    else if (stall_i)        raw_addr = pc_i;
  end

  // Only redirect targets are judged; a jump target is aligned by
  // construction so it never trips the flag.
  assign target_misaligned_o = ~rst_i & redirect & (|raw_addr[1:0]);
  assign address_o           = {raw_addr[DATA_W-1:2], 2'b00};

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage around the PC register: produces the next PC
//   (Address) and the IF/ID pipeline register with stall/flush control,
//   plus fetch/bubble performance counters and a sticky misalignment flag.
// Ports
//   Clk, Rst          clock (rising edge), asynchronous active-high reset
//   PCResult          current PC from the PC register
//   Instruction       imem read data at PCResult (combinational)
//   Stall / Flush     hazard-unit hold / squash of IF/ID
//   BranchTaken, BranchTarget, Jump, JumpIndex, JumpReg, JumpRegTarget
//                     redirect requests and their targets
//   Address           next PC, to the PC register input (zero-cycle path)
//   IFID_Instruction, IFID_PCPlus4, IFID_Valid   IF/ID register
//   FetchCount, BubbleCount   saturating performance counters
//   Misaligned        sticky: a redirect target was not word aligned
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] PCResult,
  input  logic [DATA_W-1:0] Instruction,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              BranchTaken,
  input  logic [DATA_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [25:0]       JumpIndex,
  input  logic              JumpReg,
  input  logic [DATA_W-1:0] JumpRegTarget,
  output logic [DATA_W-1:0] Address,
  output logic [DATA_W-1:0] IFID_Instruction,
  output logic [DATA_W-1:0] IFID_PCPlus4,
  output logic              IFID_Valid,
  output logic [31:0]       FetchCount,
  output logic [31:0]       BubbleCount,
  output logic              Misaligned
);

  logic [DATA_W-1:0] pc_plus4;
  logic              target_misaligned;
  logic              squash;

  fetch_state_e      state_q, state_d, evt_state;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pcp4_q, pcp4_d;
  logic              valid_q, valid_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic [31:0]       bubble_cnt_q, bubble_cnt_d;
  logic              misal_q, misal_d;

  next_pc_sel #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_next_pc_sel (
    .rst_i               (Rst),
    .pc_i                (PCResult),
    .stall_i             (Stall),
    .branch_taken_i      (BranchTaken),
    .branch_target_i     (BranchTarget),
    .jump_i              (Jump),
    .jump_index_i        (JumpIndex),
    .jump_reg_i          (JumpReg),
    .jump_reg_target_i   (JumpRegTarget),
    .address_o           (Address),
    .pc_plus4_o          (pc_plus4),
    .target_misaligned_o (target_misaligned)
  );

  // Any redirect leaves the instruction currently being fetched on the
  // wrong path, so it is squashed exactly like an explicit flush.
  assign squash = Flush | JumpReg | Jump | BranchTaken;

  // Next state: every legal state obeys the same priority; the state only
  // records what the last edge did. Illegal encodings recover to RUN.
  always_comb begin
    evt_state = ST_RUN;
    if (squash)     evt_state = ST_SQUASH;
    else if (Stall) evt_state = ST_HOLD;

    state_d = ST_RUN;
    case (state_q)
      ST_RUN, ST_HOLD, ST_SQUASH: state_d = evt_state;
      default:                    state_d = ST_RUN;
    endcase
  end

  // IF/ID, counters and sticky flag. Flush beats Stall.
  always_comb begin
    instr_d      = instr_q;
    pcp4_d       = pcp4_q;
    valid_d      = valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    misal_d      = misal_q | target_misaligned;

    if (squash) begin
      instr_d      = NOP_INSTR;
      pcp4_d       = '0;
      valid_d      = 1'b0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else if (!Stall) begin
      instr_d     = Instruction;
      pcp4_d      = pc_plus4;
      valid_d     = 1'b1;
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_RUN;
      instr_q      <= NOP_INSTR;
      pcp4_q       <= '0;
      valid_q      <= 1'b0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      misal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pcp4_q       <= pcp4_d;
      valid_q      <= valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      misal_q      <= misal_d;
    end
  end

  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pcp4_q;
  assign IFID_Valid       = valid_q;
  assign FetchCount       = fetch_cnt_q;
  assign BubbleCount      = bubble_cnt_q;
  assign Misaligned       = misal_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural PC register and an
// instruction memory whose word at address a is a ^ 32'hDEAD0000.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] PCResult, Instruction;
  logic        Stall = 1'b0, Flush = 1'b0;
  logic        BranchTaken = 1'b0, Jump = 1'b0, JumpReg = 1'b0;
  logic [31:0] BranchTarget = '0, JumpRegTarget = '0;
  logic [25:0] JumpIndex = '0;
  logic [31:0] Address, IFID_Instruction, IFID_PCPlus4, FetchCount, BubbleCount;
  logic        IFID_Valid, Misaligned;

  logic [31:0] pc_reg;
  logic        pc_ovr_en = 1'b0;
  logic [31:0] pc_ovr = '0;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  // ProgramCounter: async reset to 0, loads Address each edge.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) pc_reg <= 32'h0;
    else     pc_reg <= Address;
  end

  assign PCResult    = pc_ovr_en ? pc_ovr : pc_reg;
  assign Instruction = PCResult ^ 32'hDEAD0000;

  fetch_stage #(.DATA_W(32), .RESET_PC(32'h0)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .PCResult         (PCResult),
    .Instruction      (Instruction),
    .Stall            (Stall),
    .Flush            (Flush),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .Jump             (Jump),
    .JumpIndex        (JumpIndex),
    .JumpReg          (JumpReg),
    .JumpRegTarget    (JumpRegTarget),
    .Address          (Address),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .FetchCount       (FetchCount),
    .BubbleCount      (BubbleCount),
    .Misaligned       (Misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr,
                          input logic [31:0] pcp4, input logic valid);
    chk({tag, ".instr"}, IFID_Instruction, instr);
    chk({tag, ".pcp4"},  IFID_PCPlus4, pcp4);
    chk({tag, ".valid"}, {31'b0, IFID_Valid}, {31'b0, valid});
    $display("step %s: PC=%h Addr=%h IFID=%h/%h/%b F=%0d B=%0d M=%b",
             tag, PCResult, Address, IFID_Instruction, IFID_PCPlus4,
             IFID_Valid, FetchCount, BubbleCount, Misaligned);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst.addr", Address, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst.fetch", FetchCount, 32'd0);
    chk("rst.bubble", BubbleCount, 32'd0);
    chk("rst.misal", {31'b0, Misaligned}, 32'd0);
    chk("rst.state", {30'b0, dut.state_q}, 32'd0);
    Jump = 1'b1; JumpIndex = 26'h155;
    #1;
    chk("rst.addr_over_jump", Address, 32'h0);
    Jump = 1'b0; JumpIndex = '0;
    #4 Rst = 1'b0;   // released between edges
    #1;
    chk("run.addr0", Address, 32'h4);

    // Free run
    tick(); chk_ifid("run1", 32'hDEAD0000, 32'h4, 1'b1); chk("run1.addr", Address, 32'h8);
    tick(); chk_ifid("run2", 32'hDEAD0004, 32'h8, 1'b1);
    tick(); chk_ifid("run3", 32'hDEAD0008, 32'hC, 1'b1);
    chk("run3.fetch", FetchCount, 32'd3);
    chk("run3.addr", Address, 32'h10);
    tick(); chk_ifid("run4", 32'hDEAD000C, 32'h10, 1'b1);
    chk("run4.pc", PCResult, 32'h10);

    // Stall two cycles at PC 0x10
    Stall = 1'b1; #1;
    chk("stall.addr", Address, 32'h10);
    tick(); chk_ifid("stall1", 32'hDEAD000C, 32'h10, 1'b1);
    chk("stall1.pc", PCResult, 32'h10);
    chk("stall1.state", {30'b0, dut.state_q}, 32'd1);
    tick(); chk_ifid("stall2", 32'hDEAD000C, 32'h10, 1'b1);
    chk("stall2.addr", Address, 32'h10);
    chk("stall2.fetch", FetchCount, 32'd4);
    Stall = 1'b0;
    tick(); chk_ifid("resume", 32'hDEAD0010, 32'h14, 1'b1);
    chk("resume.fetch", FetchCount, 32'd5);
    chk("resume.state", {30'b0, dut.state_q}, 32'd0);
    tick(); tick(); tick();
    chk("pre_br.pc", PCResult, 32'h20);
    chk("pre_br.fetch", FetchCount, 32'd8);

    // Taken branch to 0x40 from 0x20
    BranchTaken = 1'b1; BranchTarget = 32'h40; #1;
    chk("br.addr", Address, 32'h40);
    tick(); chk_ifid("br_bubble", 32'h0, 32'h0, 1'b0);
    chk("br.pc", PCResult, 32'h40);
    chk("br.bubble", BubbleCount, 32'd1);
    chk("br.state", {30'b0, dut.state_q}, 32'd2);
    chk("br.fetch", FetchCount, 32'd8);
    BranchTaken = 1'b0;
    tick(); chk_ifid("br_target", 32'hDEAD0040, 32'h44, 1'b1);
    chk("br_target.fetch", FetchCount, 32'd9);

    // Redirect priority and jump target formation (combinational only)
    JumpReg = 1'b1; JumpRegTarget = 32'h80; Jump = 1'b1; JumpIndex = 26'h12;
    BranchTaken = 1'b1; BranchTarget = 32'h40; #1;
    chk("prio.addr", Address, 32'h80);
    JumpReg = 1'b0; BranchTaken = 1'b0; JumpIndex = 26'h3FFFFFF;
    pc_ovr_en = 1'b1; pc_ovr = 32'hF000_0000; #1;
    chk("jump.addr", Address, 32'hFFFF_FFFC);
    Jump = 1'b0; JumpIndex = '0; pc_ovr = 32'hFFFF_FFFC; #1;
    chk("wrap.addr", Address, 32'h0);
    pc_ovr_en = 1'b0; #1;
    chk("noedge.misal", {31'b0, Misaligned}, 32'd0);

    // Misaligned target with Stall+Flush
    BranchTaken = 1'b1; BranchTarget = 32'h43; Stall = 1'b1; Flush = 1'b1; #1;
    chk("misal.addr", Address, 32'h40);
    tick(); chk_ifid("misal_sq", 32'h0, 32'h0, 1'b0);
    chk("misal.flag", {31'b0, Misaligned}, 32'd1);
    chk("misal.bubble", BubbleCount, 32'd2);
    chk("misal.pc", PCResult, 32'h40);
    BranchTaken = 1'b0; Stall = 1'b0; Flush = 1'b0;
    tick(); chk_ifid("misal_after", 32'hDEAD0040, 32'h44, 1'b1);
    chk("misal.sticky", {31'b0, Misaligned}, 32'd1);
    chk("misal_after.fetch", FetchCount, 32'd10);

    // Flush+Stall with no redirect: PC holds, IF/ID squashed
    Stall = 1'b1; Flush = 1'b1; #1;
    chk("fs.addr", Address, 32'h44);
    tick(); chk_ifid("fs", 32'h0, 32'h0, 1'b0);
    chk("fs.pc", PCResult, 32'h44);
    chk("fs.bubble", BubbleCount, 32'd3);
    Flush = 1'b0;
    tick(); chk_ifid("hold", 32'h0, 32'h0, 1'b0);
    chk("hold.state", {30'b0, dut.state_q}, 32'd1);

    // Reset pulsed mid-stall, asynchronous
    #2 Rst = 1'b1; #1;
    chk("arst.addr", Address, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    chk("arst.fetch", FetchCount, 32'd0);
    chk("arst.bubble", BubbleCount, 32'd0);
    chk("arst.misal", {31'b0, Misaligned}, 32'd0);
    chk("arst.state", {30'b0, dut.state_q}, 32'd0);
    Stall = 1'b0;
    #1 Rst = 1'b0;
    tick(); chk_ifid("post_rst", 32'hDEAD0000, 32'h4, 1'b1);
    chk("post_rst.fetch", FetchCount, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage wrapped around the 32-bit program counter register. Computes the next address fed back into the PC (sequential, branch, jump, jump-register, or hold on stall), and registers the fetched instruction plus PC+4 into the IF/ID pipeline register with stall and flush control. Also keeps fetch and bubble performance counters and a sticky misalignment flag for the single-cycle/pipelined MIPS datapath.

## Interface
- DATA_W, 32, datapath and address width
- RESET_PC, 32'h00000000, address presented on Address while Rst is high; must equal the PC register reset value
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- PCResult  in  32  current PC from the PC register
- Instruction  in  32  instruction-memory read data at PCResult, combinational
- Stall  in  1  hazard unit: hold the PC and IF/ID
- Flush  in  1  squash IF/ID on the next edge
- BranchTaken  in  1  resolved taken branch
- BranchTarget  in  32  branch destination
- Jump  in  1  j/jal
- JumpIndex  in  26  instr[25:0] of the jump
- JumpReg  in  1  jr
- JumpRegTarget  in  32  rs value for jr
- Address  out  32  next PC, to the PC register input
- IFID_Instruction  out  32  registered instruction
- IFID_PCPlus4  out  32  registered PCResult+4
- IFID_Valid  out  1  IF/ID holds a real instruction
- FetchCount  out  32  instructions accepted into IF/ID
- BubbleCount  out  32  bubbles inserted
- Misaligned  out  1  sticky: a redirect target had bits [1:0] != 0

## Operation
- PCPlus4 = PCResult + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- Redirect = JumpReg | Jump | BranchTaken.
- Address priority: Rst -> RESET_PC; JumpReg -> JumpRegTarget; Jump -> {PCPlus4[31:28], JumpIndex, 2'b00}; BranchTaken -> BranchTarget; Stall -> PCResult; else PCPlus4.
- A redirect beats Stall.
- Address[1:0] is always forced to 00.
- Misaligned sets when a selected target has nonzero bits [1:0]. It clears only on Rst.
- FSM state register, 2 bits, encodings in the package:
  - RUN: normal fetch.
  - HOLD: previous edge was a stall.
  - SQUASH: previous edge inserted a bubble.
- FSM transitions, evaluated each edge in this priority order:
  - Flush or Redirect -> SQUASH
  - else Stall -> HOLD
  - else -> RUN
- IF/ID update per edge:
  - Flush or Redirect: Instruction <= 0 (nop), PCPlus4 <= 0, Valid <= 0. BubbleCount++.
  - Stall only: all IF/ID fields hold. No counter change.
  - Otherwise: load Instruction, PCPlus4, Valid <= 1. FetchCount++.
- Flush and Stall together: flush wins. IF/ID is squashed, and Address follows the priority list above, so it holds unless a redirect is present.
- Both counters saturate at 32'hFFFFFFFF; they do not wrap.

## Timing
- Address is combinational from the inputs and PCResult; the path is zero-cycle.
- IF/ID outputs, counters, Misaligned and FSM state update on posedge Clk.
- Latency: an instruction at PC p appears on IFID_Instruction 1 cycle after PCResult = p.
- Redirect cost: one bubble. The target is fetched on the cycle after the redirect edge.
- Reset values (asynchronous, immediate): IFID_Instruction 0, IFID_PCPlus4 0, IFID_Valid 0, FetchCount 0, BubbleCount 0, Misaligned 0, state RUN, Address = RESET_PC.
- Rst asserted mid-operation: all registers clear immediately. The first edge after release loads the instruction at RESET_PC.
- Stall held for N cycles: PCResult and IF/ID remain frozen for all N cycles. No instruction is lost or duplicated.

## Structure
- Shared package fetch_pkg holds:
  - FSM state typedef (RUN=0, HOLD=1, SQUASH=2)
  - NOP_INSTR = 32'h00000000
  - PC_INCR = 4
- Sub-module next_pc_sel: the combinational Address priority mux, including jump-target formation and alignment masking. It is reused by the hazard unit's verification model.
- The IF/ID register, FSM and counters stay in fetch_stage.

## Test plan
- Reset then free run with ProgramCounter instantiated: Address 0,4,8,… and IFID_PCPlus4 4,8,12 on successive cycles. FetchCount = 3 after 3 edges.
- Stall for 2 cycles at PCResult = 0x10: Address = 0x10 and IF/ID unchanged for both cycles. Fetch resumes with the instruction at 0x10, and FetchCount shows no loss.
- BranchTaken with target 0x40 at PCResult 0x20: next PC = 0x40, IFID_Valid = 0 for one cycle, BubbleCount = 1, FSM passes through SQUASH.
- JumpReg, Jump and BranchTaken together, with JumpRegTarget 0x80: Address = 0x80. Jump alone with JumpIndex 0x3FFFFFF at PC 0xF0000000 gives Address 0xFFFFFFFC.
- Misaligned target 0x43 plus simultaneous Stall+Flush: Address = 0x40, Misaligned = 1 (stays 1 until Rst), and IF/ID squashed.
- Rst pulsed mid-stall, and PCResult = 0xFFFFFFFC: all outputs return to reset values asynchronously. The PC+4 wrap test shows Address = 0 at PCResult 0xFFFFFFFC.
